aes_key_expander: RTL and testbench

- Iterative AES-128 key-schedule unit that sits directly upstream of the AES single-round datapath.
- Takes a 128-bit cipher key packed in the same word/byte order the CPU uses when it gathers four GPRs: register base+0 goes to bits [31:0].
- Computes all NR+1 round keys at one 32-bit word per cycle and stores them internally.
- The sequencer reads the stored keys back by round index and drives them into the AES core's key input.

---
 rtl/aes_key_expander.sv | 171 +++++++++++++++++
 tb/tb_aes_key_expander.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: one 32-bit word per cycle into a local store,
// round keys read back by index as a registered 128-bit sample.
module aes_key_expander #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    input  logic         rk_rd,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         rk_valid
);

    localparam int NW = 4 * (NR + 1);

    if (NR != 10) begin : g_bad_nr
        $error("aes_key_expander supports only NR=10");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [5:0]     r_i;
    logic [7:0]     r_rcon;
    logic           r_busy;
    logic           r_done;
    logic           r_valid;
    logic [127:0]   r_rk;
    logic [31:0]    r_w [0:NW-1];

    logic           w_accept;
    logic           w_expand;
    logic           w_rcon_step;
    logic           w_last;
    logic [31:0]    w_prev;
    logic [31:0]    w_rot;
    logic [31:0]    w_temp;
    logic [31:0]    w_new;
    logic [7:0]     w_xtime;
    logic [5:0]     w_base;
    logic           w_idx_ok;
    logic [127:0]   w_rk_sel;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box: inverse as a^254 in GF(2^8), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

    assign w_accept    = start && reset_n && (r_state != S_EXPAND);
    assign w_expand    = reset_n && (r_state == S_EXPAND);
    assign w_rcon_step = (r_i[1:0] == 2'b00);
    assign w_last      = (r_i == 6'(NW - 1));
    assign w_xtime     = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    assign w_prev = r_w[r_i - 6'd1];
    assign w_rot  = {w_prev[7:0], w_prev[31:8]};

    always_comb begin
        w_temp = w_prev;
        if (w_rcon_step) begin
            w_temp = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                      sbox(w_rot[15:8]),  sbox(w_rot[7:0]) ^ r_rcon};
        end
    end

    assign w_new = r_w[r_i - 6'd4] ^ w_temp;

    assign w_base   = {rk_idx, 2'b00};
    assign w_idx_ok = (rk_idx <= 4'(NR));

    always_comb begin
        w_rk_sel = '0;
        if (w_idx_ok) begin
            w_rk_sel = {r_w[w_base + 6'd3], r_w[w_base + 6'd2],
                        r_w[w_base + 6'd1], r_w[w_base]};
        end
    end

    // Store is not reset; reads see old contents on the same edge as writes.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_w[0] <= key_in[31:0];
            r_w[1] <= key_in[63:32];
            r_w[2] <= key_in[95:64];
            r_w[3] <= key_in[127:96];
        end else if (w_expand) begin
            r_w[r_i] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_i     <= 6'd0;
            r_rcon  <= 8'h01;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_EXPAND;
                        r_i     <= 6'd4;
                        r_rcon  <= 8'h01;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_EXPAND: begin
                    r_i <= r_i + 6'd1;
                    if (w_rcon_step) r_rcon <= w_xtime;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rk    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= rk_rd;
            if (rk_rd) r_rk <= w_rk_sel;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rk_out   = r_rk;
    assign rk_valid = r_valid;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander: known-answer round keys, latency,
// ignored start, mid-run reset and read-before-write on restart.
module tb_aes_key_expander;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         rk_rd;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         rk_valid;

    int n_cmp;
    int n_err;

    localparam logic [127:0] K_FIPS = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] K_ZERO = 128'h0;
    localparam logic [127:0] F_R1   = 128'h05766c2a3939a323b12c548817fefaa0;
    localparam logic [127:0] F_R2   = 128'h7ff659737a80355943b9967af295c2f2;
    localparam logic [127:0] F_R10  = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
    localparam logic [127:0] Z_R1   = 128'h63636362636363626363636263636362;
    localparam logic [127:0] Z_R2   = 128'haafbfbf9c998989baafbfbf9c998989b;
    localparam logic [127:0] Z_R10  = 128'h8e188f6fcf51e92311e2923ecb5befb4;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [0:8];

    aes_key_expander #(.NR(10)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .done     (done),
        .rk_rd    (rk_rd),
        .rk_idx   (rk_idx),
        .rk_out   (rk_out),
        .rk_valid (rk_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_read(input string nm, input logic [3:0] idx, input logic [127:0] exp);
        @(negedge clk);
        rk_rd  = 1'b1;
        rk_idx = idx;
        @(posedge clk);
        #1;
        check({nm, " valid"}, 128'(rk_valid), 128'd1);
        check(nm, rk_out, exp);
        @(negedge clk);
        rk_rd = 1'b0;
        @(posedge clk);
        #1;
        check({nm, " valid pulse"}, 128'(rk_valid), 128'd0);
    endtask

    // Pulse start, optionally re-pulse start after inj busy cycles, count busy cycles.
    task automatic run_expand(input logic [127:0] key, input int inj,
                              input logic [127:0] inj_key, output int cyc);
        int guard;
        cyc   = 0;
        guard = 0;
        @(negedge clk);
        start  = 1'b1;
        key_in = key;
        forever begin
            @(negedge clk);
            start  = 1'b0;
            key_in = key;
            guard++;
            if (busy) cyc++;
            if (done && !busy) break;
            if (guard > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL expand timeout: busy=%0b done=%0b", busy, done);
                break;
            end
            if (cyc == inj) begin
                start  = 1'b1;
                key_in = inj_key;
            end
        end
    endtask

    initial begin
        int   cyc;
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        key_in  = '0;
        rk_rd   = 1'b0;
        rk_idx  = '0;

        vecs[0] = '{K_FIPS, 4'd0,  K_FIPS};
        vecs[1] = '{K_FIPS, 4'd1,  F_R1};
        vecs[2] = '{K_FIPS, 4'd2,  F_R2};
        vecs[3] = '{K_FIPS, 4'd10, F_R10};
        vecs[4] = '{K_ZERO, 4'd1,  Z_R1};
        vecs[5] = '{K_ZERO, 4'd2,  Z_R2};
        vecs[6] = '{K_ZERO, 4'd10, Z_R10};
        vecs[7] = '{K_ZERO, 4'd11, 128'h0};
        vecs[8] = '{K_ZERO, 4'd15, 128'h0};

        #3;
        check("reset busy", 128'(busy), 128'd0);
        check("reset done", 128'(done), 128'd0);
        check("reset valid", 128'(rk_valid), 128'd0);
        check("reset rk_out", rk_out, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            if (v == 0 || vecs[v].key != vecs[v-1].key) begin
                run_expand(vecs[v].key, -1, '0, cyc);
                check($sformatf("busy cycles v%0d", v), 128'(cyc), 128'd40);
                check($sformatf("done v%0d", v), 128'(done), 128'd1);
            end
            do_read($sformatf("vec%0d idx%0d", v, vecs[v].idx), vecs[v].idx, vecs[v].exp);
        end

        // start during EXPAND must be ignored
        run_expand(K_FIPS, 10, K_ZERO, cyc);
        check("ignored start busy cycles", 128'(cyc), 128'd40);
        do_read("ignored start idx10", 4'd10, F_R10);
        do_read("ignored start idx0", 4'd0, K_FIPS);

        // asynchronous reset mid-expansion
        @(negedge clk);
        start  = 1'b1;
        key_in = K_FIPS;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre-reset busy", 128'(busy), 128'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset busy", 128'(busy), 128'd0);
        check("async reset done", 128'(done), 128'd0);
        check("async reset rk_out", rk_out, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("after reset done", 128'(done), 128'd0);
        run_expand(K_FIPS, -1, '0, cyc);
        check("post-reset busy cycles", 128'(cyc), 128'd40);
        do_read("post-reset idx1", 4'd1, F_R1);

        // restart with simultaneous read: read sees the old schedule
        @(negedge clk);
        start  = 1'b1;
        key_in = K_ZERO;
        rk_rd  = 1'b1;
        rk_idx = 4'd10;
        @(posedge clk);
        #1;
        check("rbw valid", 128'(rk_valid), 128'd1);
        check("rbw idx10", rk_out, F_R10);
        check("rbw done fell", 128'(done), 128'd0);
        check("rbw busy", 128'(busy), 128'd1);
        @(negedge clk);
        start = 1'b0;
        rk_rd = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rbw new done", 128'(done), 128'd1);
        do_read("rbw zero idx1", 4'd1, Z_R1);
        do_read("rbw zero idx10", 4'd10, Z_R10);
        do_read("rbw zero idx0", 4'd0, K_ZERO);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
